// File: rtl/stack_seq_pkg.sv
// Shared constants for the stack calculator sequencer: FSM encoding, opcode
// values and the per-opcode execute schedule used to replay programs.
package stack_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CRST  = 2'd1,
    ST_FETCH = 2'd2,
    ST_EXEC  = 2'd3
  } seq_state_e;

  localparam logic [3:0] OP_NOOP = 4'h0;
  localparam logic [3:0] OP_PUSH = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_POP  = 4'h3;
  localparam logic [3:0] OP_SWAP = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_PUSF = 4'h6;
  localparam logic [3:0] OP_REPL = 4'h7;
  localparam logic [3:0] OP_BINA = 4'h8;
  localparam logic [3:0] OP_MULT = 4'h9;
  localparam logic [3:0] OP_DIV  = 4'hA;
  localparam logic [3:0] OP_DUP  = 4'hB;

  function automatic logic [1:0] op_exec_cycles(input logic [3:0] op);
    case (op)
      OP_PUSH, OP_ADD, OP_SUB, OP_PUSF, OP_REPL, OP_BINA: op_exec_cycles = 2'd2;
      OP_MULT, OP_DIV:                                    op_exec_cycles = 2'd3;
      default:                                            op_exec_cycles = 2'd1;
    endcase
  endfunction

  function automatic logic op_has_operand(input logic [3:0] op);
    case (op)
      OP_PUSH, OP_PUSF, OP_REPL, OP_BINA: op_has_operand = 1'b1;
      default:                            op_has_operand = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seq_program_ram.sv
// Nibble program store: synchronous write, asynchronous read. Contents are
// deliberately left uninitialised by reset.
module seq_program_ram #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [3:0]        wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [3:0]        rdata_o
);

  logic [3:0] mem_q [DEPTH];

  // Program write port
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stack_cpu_sequencer.sv
// Replays a serially loaded nibble program into the stack core, presenting
// each opcode/operand for exactly the cycles the core's schedule samples it.
module stack_cpu_sequencer
  import stack_seq_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_en_i,
  input  logic [3:0]      load_data_i,
  input  logic            start_i,
  input  logic            loop_en_i,
  input  logic            stop_i,
  output logic [3:0]      cpu_inbits_o,
  output logic            cpu_rst_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [ADDR_W:0] prog_len_o
);

  localparam logic [ADDR_W:0] FULL_LEN = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);

  seq_state_e      state_q, state_d;
  logic [ADDR_W:0] pc_q, pc_d, len_q, len_d, pc_inc, next_pc;
  logic [3:0]      op_q, op_d, inbits_q, inbits_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            loop_q, loop_d, stop_q, stop_d, stop_pend;
  logic            crst_q, crst_d, busy_q, busy_d, done_q, done_d;
  logic            ram_we;
  logic [ADDR_W-1:0] ram_raddr;
  logic [3:0]      ram_rdata;

  seq_program_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (len_q[ADDR_W-1:0]),
    .wdata_i (load_data_i),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  assign pc_inc    = pc_q + ONE;
  assign next_pc   = pc_q + {{ADDR_W{1'b0}}, op_has_operand(op_q)};
  assign stop_pend = stop_q | stop_i;

  // Next-state and next-output computation; outputs are registered with the state
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    len_d     = len_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    loop_d    = loop_q;
    stop_d    = stop_q;
    inbits_d  = inbits_q;
    crst_d    = 1'b0;
    done_d    = 1'b0;
    ram_we    = 1'b0;
    ram_raddr = '0;
    case (state_q)
      ST_IDLE: begin
        inbits_d = 4'h0;
        if (load_en_i) begin
          if (len_q != FULL_LEN) begin
            ram_we = 1'b1;
            len_d  = len_q + ONE;
          end else begin
            len_d = len_q;
          end
        end else if (start_i) begin
          if (len_q != '0) begin
            state_d = ST_CRST;
            crst_d  = 1'b1;
            pc_d    = '0;
            loop_d  = loop_en_i;
            stop_d  = 1'b0;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CRST: begin
        ram_raddr = '0;
        inbits_d  = ram_rdata;
        state_d   = ST_FETCH;
      end
      ST_FETCH: begin
        // The opcode is already on the output register, so the read port is free for the operand
        stop_d    = stop_pend;
        op_d      = inbits_q;
        cnt_d     = op_exec_cycles(inbits_q) - 2'd1;
        pc_d      = pc_inc;
        ram_raddr = pc_inc[ADDR_W-1:0];
        if (op_has_operand(inbits_q) && (pc_inc < len_q)) begin
          inbits_d = ram_rdata;
        end else begin
          inbits_d = 4'h0;
        end
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        stop_d = stop_pend;
        if (cnt_q != 2'd0) begin
          cnt_d = cnt_q - 2'd1;
        end else if (stop_pend) begin
          stop_d   = 1'b0;
          inbits_d = 4'h0;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end else if (next_pc >= len_q) begin
          if (loop_q) begin
            pc_d      = '0;
            ram_raddr = '0;
            inbits_d  = ram_rdata;
            state_d   = ST_FETCH;
          end else begin
            inbits_d = 4'h0;
            done_d   = 1'b1;
            state_d  = ST_IDLE;
          end
        end else begin
          pc_d      = next_pc;
          ram_raddr = next_pc[ADDR_W-1:0];
          inbits_d  = ram_rdata;
          state_d   = ST_FETCH;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        inbits_d = 4'h0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      len_q    <= '0;
      op_q     <= 4'h0;
      cnt_q    <= 2'd0;
      loop_q   <= 1'b0;
      stop_q   <= 1'b0;
      inbits_q <= 4'h0;
      crst_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      len_q    <= len_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      loop_q   <= loop_d;
      stop_q   <= stop_d;
      inbits_q <= inbits_d;
      crst_q   <= crst_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // The core is held in reset for as long as the chip reset is asserted
  assign cpu_rst_o    = crst_q | rst;
  assign cpu_inbits_o = inbits_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign prog_len_o   = len_q;

endmodule

// File: tb/tb_stack_cpu_sequencer.sv
// Directed and randomized checks of the program sequencer against a
// trace model built from the opcode schedule table.
module tb_stack_cpu_sequencer;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic            clk = 1'b0;
  logic            rst, load_en, start, loop_en, stop;
  logic [3:0]      load_data;
  logic [3:0]      cpu_inbits;
  logic            cpu_rst, busy, done;
  logic [ADDR_W:0] prog_len;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  int prog[$];
  int exp_in[$];
  int exp_end[$];
  int ex_tab[16] = '{1, 2, 2, 1, 1, 2, 2, 2, 2, 3, 3, 1, 1, 1, 1, 1};

  stack_cpu_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_en_i    (load_en),
    .load_data_i  (load_data),
    .start_i      (start),
    .loop_en_i    (loop_en),
    .stop_i       (stop),
    .cpu_inbits_o (cpu_inbits),
    .cpu_rst_o    (cpu_rst),
    .busy_o       (busy),
    .done_o       (done),
    .prog_len_o   (prog_len)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit takes_operand(input int op);
    return (op == 1) || (op == 6) || (op == 7) || (op == 8);
  endfunction

  // Expected per-cycle inbits from the first FETCH, plus instruction-end markers
  task automatic build_trace(input int passes);
    exp_in.delete();
    exp_end.delete();
    for (int p = 0; p < passes; p++) begin
      int i = 0;
      while (i < prog.size()) begin
        int op = prog[i];
        bit has = takes_operand(op);
        int opnd = (has && (i + 1 < prog.size())) ? prog[i+1] : 0;
        exp_in.push_back(op);
        exp_end.push_back(0);
        for (int c = 0; c < ex_tab[op]; c++) begin
          exp_in.push_back(has ? opnd : 0);
          exp_end.push_back(c == ex_tab[op] - 1);
        end
        i += has ? 2 : 1;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_cpu_rst", {7'd0, cpu_rst}, 8'd1);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_done", {7'd0, done}, 8'd0);
    check("rst_inbits", {4'd0, cpu_inbits}, 8'd0);
    check("rst_len", {2'd0, prog_len}, 8'd0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_cpu_rst", {7'd0, cpu_rst}, 8'd0);
    check("post_rst_done", {7'd0, done}, 8'd0);
  endtask

  task automatic load_prog();
    foreach (prog[k]) begin
      load_en = 1'b1;
      load_data = 4'(prog[k]);
      tick();
    end
    load_en = 1'b0;
    check("prog_len", {2'd0, prog_len}, 8'(prog.size() > DEPTH ? DEPTH : prog.size()));
  endtask

  task automatic run_check(input bit loop, input int stop_at, input string tag);
    int n = exp_in.size();
    if (stop_at >= 0) begin
      int k = stop_at;
      while (exp_end[k] == 0) k++;
      n = k + 1;
    end
    loop_en = loop;
    start = 1'b1;
    tick();
    start = 1'b0;
    loop_en = 1'b0;
    check({tag, "_crst_rst"}, {7'd0, cpu_rst}, 8'd1);
    check({tag, "_crst_in"}, {4'd0, cpu_inbits}, 8'd0);
    check({tag, "_crst_busy"}, {7'd0, busy}, 8'd1);
    for (int k = 0; k < n; k++) begin
      tick();
      stop = (k == stop_at);
      check($sformatf("%s_in[%0d]", tag, k), {4'd0, cpu_inbits}, 8'(exp_in[k]));
      check($sformatf("%s_busy[%0d]", tag, k), {7'd0, busy}, 8'd1);
      check($sformatf("%s_rst[%0d]", tag, k), {7'd0, cpu_rst}, 8'd0);
      check($sformatf("%s_done[%0d]", tag, k), {7'd0, done}, 8'd0);
    end
    tick();
    stop = 1'b0;
    check({tag, "_done"}, {7'd0, done}, 8'd1);
    check({tag, "_idle_busy"}, {7'd0, busy}, 8'd0);
    check({tag, "_idle_in"}, {4'd0, cpu_inbits}, 8'd0);
    tick();
    check({tag, "_done_clr"}, {7'd0, done}, 8'd0);
  endtask

  initial begin
    rst = 1'b1; load_en = 1'b0; load_data = 4'h0;
    start = 1'b0; loop_en = 1'b0; stop = 1'b0;
    tick();
    do_reset();

    prog = '{1, 3, 1, 4, 8, 0, 3};
    load_prog();
    build_trace(1);
    run_check(1'b0, -1, "basic");

    do_reset();
    prog = '{9, 10};
    load_prog();
    build_trace(1);
    run_check(1'b0, -1, "muldiv");

    do_reset();
    prog = '{9, 1, 5, 2, 3, 8, 2, 4};
    load_prog();
    build_trace(3);
    run_check(1'b1, 18, "loopstop");

    do_reset();
    prog = '{1};
    load_prog();
    build_trace(1);
    run_check(1'b0, -1, "trunc");

    // Load collides with start: the load must win
    load_en = 1'b1; load_data = 4'h3; start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    check("ldstart_busy", {7'd0, busy}, 8'd0);
    check("ldstart_len", {2'd0, prog_len}, 8'd2);

    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("empty_done", {7'd0, done}, 8'd1);
    check("empty_cpu_rst", {7'd0, cpu_rst}, 8'd0);
    check("empty_busy", {7'd0, busy}, 8'd0);
    tick();
    check("empty_done_clr", {7'd0, done}, 8'd0);

    prog.delete();
    for (int k = 0; k < 33; k++) prog.push_back(int'($urandom_range(0, 15)));
    load_prog();

    // Reset during the execute phase of a MULT
    do_reset();
    prog = '{9, 0};
    load_prog();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("mult_exec_busy", {7'd0, busy}, 8'd1);
    do_reset();
    prog = '{1, 3, 1, 4, 8, 0, 3};
    load_prog();
    build_trace(1);
    run_check(1'b0, -1, "rerun");

    for (int r = 0; r < 8; r++) begin
      bit lp = r[0];
      int len = int'($urandom_range(1, 12));
      int stop_at;
      do_reset();
      prog.delete();
      for (int k = 0; k < len; k++) prog.push_back(int'($urandom_range(0, 15)));
      load_prog();
      build_trace(lp ? 3 : 1);
      if (lp) stop_at = int'($urandom_range(0, (exp_in.size() * 2) / 3));
      else if (r[1]) stop_at = int'($urandom_range(0, exp_in.size() - 1));
      else stop_at = -1;
      run_check(lp, stop_at, $sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
